noc_ring_route_unit: RTL
========================

// Module: noc_ring_route_unit
// PURPOSE
// - Clocked, parametrised ring routing unit for one NoC router slice: accepts flits on an ingress port, decodes dest router ID, steers each flit to LOCAL, CW or CCW output.
// - Independent egress path registers flits from the output arbiter onto the link toward the next router.
// - Successor to the fixed 8-router/3-bit hop-decode route logic: generic ring size, shortest-path direction select, registered valid/ready handshakes, illegal-destination detection.
// PARAMETERS
// - WIDTH        11  flit width in bits
// - NUM_ROUTERS  8   routers on the ring, 2..2**ID_W
// - ID_W         3   dest ID field width
// - ID_LSB       1   LSB position of dest ID in flit (field = flit[ID_LSB+ID_W-1:ID_LSB])
// - SOURCE_ID    2   this router's ID, < NUM_ROUTERS
// PORTS
// - clk        in   1        clock, all state on rising edge
// - rst_n      in   1        async assert, active-low reset
// - in_valid   in   1        ingress flit valid
// - in_ready   out  1        ingress can accept
// - in_data    in   WIDTH    ingress flit
// - rt_valid   out  3        per-direction valid: [0]=LOCAL [1]=CW [2]=CCW
// - rt_ready   in   3        per-direction ready, same bit order
// - rt_data    out  WIDTH    routed flit (shared bus, qualified by rt_valid)
// - arb_valid  in   1        arbiter-output flit valid
// - arb_ready  out  1        egress can accept
// - arb_data   in   WIDTH    arbiter-output flit
// - eg_valid   out  1        egress link valid
// - eg_ready   in   1        egress link ready
// - eg_data    out  WIDTH    egress flit
// - err_illegal out 1        1-cycle pulse: flit with dest ID >= NUM_ROUTERS dropped
// BEHAVIOUR
// - Reset (rst_n=0, immediate): rt_valid=0, eg_valid=0, err_illegal=0, rt_data/eg_data=0, both holding regs empty; in-flight flits discarded. in_ready/arb_ready=0 during reset, 1 first cycle after release.
// - Handshake: transfer when valid&ready at rising edge. Sender holds data stable while valid&!ready. valid never drops without a transfer.
// - Route path: 1-entry holding reg, FSM EMPTY/FULL.
//   - EMPTY: in_ready=1; on in_valid capture flit + decoded dir -> FULL (illegal dest: drop, pulse err_illegal, stay EMPTY).
//   - FULL: rt_valid[dir]=1 (one-hot). in_ready = rt_ready[dir] (bypass: simultaneous drain+fill allowed). Drain & no fill -> EMPTY; drain & fill -> FULL with new flit; no drain -> hold, in_ready=0.
//   - Latency 1 cycle ingress accept -> rt_valid; throughput 1 flit/cycle with ready=1.
// - Direction decode: d = dest >= SOURCE_ID ? dest-SOURCE_ID : dest+NUM_ROUTERS-SOURCE_ID (ID_W+1 bits, no wrap before compare).
//   - d==0 -> LOCAL; 1 <= d <= NUM_ROUTERS/2 -> CW; else CCW. Even ring, d==NUM_ROUTERS/2: CW (fixed tie-break).
// - Illegal: dest >= NUM_ROUTERS. Flit consumed (in_ready not lowered for it), never emitted, err_illegal=1 next cycle only. Back-to-back illegal flits -> pulse each cycle.
// - Egress path: identical 1-entry reg/FSM, arb_* -> eg_*, 1-cycle latency, bypass ready = eg_ready when FULL. No decode, no drop.
// - Paths fully independent; simultaneous activity never stalls the other.
// - rt_ready bits for non-selected directions ignored.
// CONFIGURATION
// - ROUTE_STATS_EN defined: adds outputs stat_local, stat_cw, stat_ccw, stat_drop (16 bits each), incremented on each completed rt transfer / illegal drop; saturate at 16'hFFFF; cleared by rst_n.
// - ROUTE_STATS_EN undefined: no counters, no stat ports; behaviour otherwise identical.
// TESTING (NUM_ROUTERS=8, ID_W=3, ID_LSB=1, SOURCE_ID=2 unless noted)
// - in_data dest=2, all rt_ready=1 -> rt_valid=3'b001 one cycle after accept, rt_data==in_data.
// - dest=3 (d=1) -> 3'b010; dest=1 (d=7) -> 3'b100; dest=6 (d=4 tie) -> 3'b010.
// - 4 back-to-back flits, dests 2,3,1,5, rt_ready=3'b111 -> 4 outputs on 4 consecutive cycles, order preserved, in_ready stays 1.
// - dest=3 with rt_ready[1]=0 for 5 cycles -> rt_valid held, rt_data stable, in_ready=0; release -> drain, next flit accepted same edge.
// - NUM_ROUTERS=6: dest=7 -> no rt_valid, err_illegal pulse 1 cycle; with ROUTE_STATS_EN stat_drop=1.
// - arb flits streaming with eg_ready toggling 1/0 while route path busy -> eg order preserved, no loss; rst_n low mid-stream -> all valids 0 asynchronously, no stale flit after release.

Source files
------------

// File: rtl/noc_ring_route_unit.sv
`default_nettype none
// ============================================================================
// Module   : noc_ring_route_unit
// Brief    : Ring NoC route slice: shortest-path LOCAL/CW/CCW steering of
//            ingress flits plus an independent registered egress stage.
//            Optional macro ROUTE_STATS_EN adds saturating traffic counters.
// Revision : 1.0 - initial release
// ============================================================================
module noc_ring_route_unit #(
  parameter int WIDTH       = 11,
  parameter int NUM_ROUTERS = 8,
  parameter int ID_W        = 3,
  parameter int ID_LSB      = 1,
  parameter int SOURCE_ID   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [2:0]       rt_valid,
  input  logic [2:0]       rt_ready,
  output logic [WIDTH-1:0] rt_data,
  input  logic             arb_valid,
  output logic             arb_ready,
  input  logic [WIDTH-1:0] arb_data,
  output logic             eg_valid,
  input  logic             eg_ready,
  output logic [WIDTH-1:0] eg_data,
`ifdef ROUTE_STATS_EN
  output logic [15:0]      stat_local,
  output logic [15:0]      stat_cw,
  output logic [15:0]      stat_ccw,
  output logic [15:0]      stat_drop,
`endif
  output logic             err_illegal
);

  localparam int DW = ID_W + 1;
  localparam logic [DW-1:0] c_NR   = DW'(NUM_ROUTERS);
  localparam logic [DW-1:0] c_SRC  = DW'(SOURCE_ID);
  localparam logic [DW-1:0] c_HALF = DW'(NUM_ROUTERS / 2);

  typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t           r_rt_st;
  state_t           r_eg_st;
  logic             r_live;
  logic [2:0]       r_rt_valid;
  logic [WIDTH-1:0] r_rt_data;
  logic             r_err;
  logic             r_eg_valid;
  logic [WIDTH-1:0] r_eg_data;

  logic [DW-1:0]    w_dest;
  logic [DW-1:0]    w_dist;
  logic             w_illegal;
  logic [2:0]       w_dir;
  logic [2:0]       w_drain_vec;
  logic             w_rt_drain;
  logic             w_in_fire;
  logic             w_arb_fire;

  // Dest widened by one bit so dest+NUM_ROUTERS cannot wrap before the compare.
  assign w_dest    = {1'b0, in_data[ID_LSB +: ID_W]};
  assign w_illegal = (w_dest >= c_NR);
  assign w_dist    = (w_dest >= c_SRC) ? (w_dest - c_SRC) : (w_dest + c_NR - c_SRC);
  assign w_dir     = (w_dist == '0)     ? 3'b001 :
                     (w_dist <= c_HALF) ? 3'b010 : 3'b100;

  // rt_valid is one-hot when full, so any matching ready bit is a drain.
  assign w_drain_vec = r_rt_valid & rt_ready;
  assign w_rt_drain  = |w_drain_vec;
  assign in_ready    = r_live & ((r_rt_st == ST_EMPTY) | w_rt_drain);
  assign w_in_fire   = in_valid & in_ready;
  assign arb_ready   = r_live & ((r_eg_st == ST_EMPTY) | eg_ready);
  assign w_arb_fire  = arb_valid & arb_ready;

  assign rt_valid    = r_rt_valid;
  assign rt_data     = r_rt_data;
  assign err_illegal = r_err;
  assign eg_valid    = r_eg_valid;
  assign eg_data     = r_eg_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rt_st    <= ST_EMPTY;
      r_rt_valid <= '0;
      r_rt_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_in_fire & w_illegal;
      case (r_rt_st)
        ST_EMPTY: begin
          if (w_in_fire && !w_illegal) begin
            r_rt_st    <= ST_FULL;
            r_rt_valid <= w_dir;
            r_rt_data  <= in_data;
          end
        end
        ST_FULL: begin
          if (w_in_fire && !w_illegal) begin
            r_rt_valid <= w_dir;
            r_rt_data  <= in_data;
          end else if (w_rt_drain) begin
            r_rt_st    <= ST_EMPTY;
            r_rt_valid <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eg_st    <= ST_EMPTY;
      r_eg_valid <= 1'b0;
      r_eg_data  <= '0;
    end else begin
      case (r_eg_st)
        ST_EMPTY: begin
          if (w_arb_fire) begin
            r_eg_st    <= ST_FULL;
            r_eg_valid <= 1'b1;
            r_eg_data  <= arb_data;
          end
        end
        ST_FULL: begin
          if (w_arb_fire) begin
            r_eg_data  <= arb_data;
          end else if (eg_ready) begin
            r_eg_st    <= ST_EMPTY;
            r_eg_valid <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef ROUTE_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_local <= '0;
      stat_cw    <= '0;
      stat_ccw   <= '0;
      stat_drop  <= '0;
    end else begin
      stat_local <= sat_inc(stat_local, w_drain_vec[0]);
      stat_cw    <= sat_inc(stat_cw,    w_drain_vec[1]);
      stat_ccw   <= sat_inc(stat_ccw,   w_drain_vec[2]);
      stat_drop  <= sat_inc(stat_drop,  w_in_fire & w_illegal);
    end
  end
`endif

endmodule
`default_nettype wire
